// File: rtl/riscv_pkg.sv
// RV32I decode constants, ALU encodings, instruction field positions and immediate helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package riscv_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 values legal in RV32I
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation encodings
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Instruction field LSB positions
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} src1_sel_e;

  // Assemble the 32-bit sign-extended immediate for a given format
  function automatic logic [31:0] build_imm(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Map funct3 (+ alternate bit) to an ALU operation
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Purely combinational RV32I decoder: immediate, ALU op, class flags, source usage, illegal.
// Latency: zero (combinational).
// Backpressure: none; the enclosing stage decides when results are captured.
module id_decoder
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic [31:0]         inst,
  output logic [XLEN-1:0]     imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                rd_we,
  output logic                is_load,
  output logic                is_store,
  output logic                is_branch,
  output logic                is_jump,
  output logic                uses_rs1,
  output logic                uses_rs2,
  output src1_sel_e           src1_sel,
  output logic                src2_imm,
  output logic                illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  imm_fmt_e   fmt;
  logic [3:0] alu;
  logic       wr;

  assign opcode = inst[OPC_LSB +: 7];
  assign f3     = inst[F3_LSB +: 3];
  assign f7     = inst[F7_LSB +: 7];
  assign rd     = inst[RD_LSB +: 5];
  assign imm    = XLEN'($signed(build_imm(inst, fmt)));
  assign alu_op = ALU_OP_W'(alu);
  assign rd_we  = wr && (rd != 5'd0);

  // Opcode-driven decode; illegal encodings suppress every side-effect flag
  always_comb begin
    fmt       = IMM_NONE;
    alu       = ALU_ADD;
    wr        = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    src1_sel  = SRC1_RS1;
    src2_imm  = 1'b1;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        wr       = 1'b1;
        src2_imm = 1'b0;
        alu      = alu_from_f3(f3, f7[5]);
        illegal  = !((f7 == F7_BASE) ||
                     ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR))));
      end
      OPC_OP_IMM: begin
        fmt      = IMM_I;
        uses_rs1 = 1'b1;
        wr       = 1'b1;
        // Only shift-right distinguishes variants; ADDI must never turn into SUB
        alu      = alu_from_f3(f3, (f3 == F3_SR) && f7[5]);
        if (f3 == F3_SLL) illegal = (f7 != F7_BASE);
        if (f3 == F3_SR)  illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
      end
      OPC_LOAD: begin
        fmt      = IMM_I;
        uses_rs1 = 1'b1;
        wr       = 1'b1;
        is_load  = 1'b1;
      end
      OPC_STORE: begin
        fmt      = IMM_S;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        is_store = 1'b1;
      end
      OPC_BRANCH: begin
        fmt       = IMM_B;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_branch = 1'b1;
        src2_imm  = 1'b0;
        alu       = ALU_SUB;
      end
      OPC_LUI: begin
        fmt      = IMM_U;
        wr       = 1'b1;
        src1_sel = SRC1_ZERO;
      end
      OPC_AUIPC: begin
        fmt      = IMM_U;
        wr       = 1'b1;
        src1_sel = SRC1_PC;
      end
      OPC_JAL: begin
        fmt      = IMM_J;
        wr       = 1'b1;
        is_jump  = 1'b1;
        src1_sel = SRC1_PC;
      end
      OPC_JALR: begin
        fmt      = IMM_I;
        uses_rs1 = 1'b1;
        wr       = 1'b1;
        is_jump  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      wr        = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_id_stage.sv
// RV32I ID stage: decode, regfile read with write-back bypass, load-use stall, ID/EX register.
// Latency: one cycle from IF acceptance to ex_* valid.
// Backpressure: ex_* hold while ex_valid && !ex_ready; if_ready drops on stall, hazard or flush.
module pipeline_id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [31:0]         if_inst,
  input  logic [XLEN-1:0]     if_pc,
  input  logic                flush,
  output logic [REG_AW-1:0]   rf_raddr1,
  output logic [REG_AW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0]     rf_rdata1,
  input  logic [XLEN-1:0]     rf_rdata2,
  input  logic                wb_we,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_src1,
  output logic [XLEN-1:0]     ex_src2,
  output logic [XLEN-1:0]     ex_store_data,
  output logic [XLEN-1:0]     ex_imm,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                ex_rd_we,
  output logic                ex_is_load,
  output logic                ex_is_store,
  output logic                ex_is_branch,
  output logic                ex_is_jump,
  output logic [2:0]          ex_funct3,
  output logic                ex_illegal
);

  logic [REG_AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0]     imm, rs1_val, rs2_val, src1, src2;
  logic [ALU_OP_W-1:0] alu_op;
  logic                rd_we, is_load, is_store, is_branch, is_jump;
  logic                uses_rs1, uses_rs2, src2_imm, illegal;
  src1_sel_e           src1_sel;
  logic                advance, hazard, accept;

  assign rs1       = REG_AW'(if_inst[RS1_LSB +: 5]);
  assign rs2       = REG_AW'(if_inst[RS2_LSB +: 5]);
  assign rd        = REG_AW'(if_inst[RD_LSB +: 5]);
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  id_decoder #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) u_dec (
    .inst      (if_inst),
    .imm       (imm),
    .alu_op    (alu_op),
    .rd_we     (rd_we),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .src1_sel  (src1_sel),
    .src2_imm  (src2_imm),
    .illegal   (illegal)
  );

  // A load still in ID/EX cannot feed the instruction behind it; stall one slot
  assign hazard   = ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  assign advance  = !ex_valid || ex_ready;
  assign if_ready = advance && !hazard && !flush;
  assign accept   = if_valid && if_ready;

  // Operand read: x0 is hard zero, otherwise a same-cycle write-back wins over the regfile
  always_comb begin
    rs1_val = rf_rdata1;
    rs2_val = rf_rdata2;
    if (rs1 == '0)                         rs1_val = '0;
    else if (wb_we && (wb_rd == rs1))      rs1_val = wb_data;
    if (rs2 == '0)                         rs2_val = '0;
    else if (wb_we && (wb_rd == rs2))      rs2_val = wb_data;
  end

  // Operand A/B muxing by instruction class
  always_comb begin
    case (src1_sel)
      SRC1_PC:   src1 = if_pc;
      SRC1_ZERO: src1 = '0;
      default:   src1 = rs1_val;
    endcase
    src2 = src2_imm ? imm : rs2_val;
  end

  // ID/EX register: flush squashes, bubbles only clear valid so payload never goes X
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_src1       <= '0;
      ex_src2       <= '0;
      ex_store_data <= '0;
      ex_imm        <= '0;
      ex_alu_op     <= '0;
      ex_rd         <= '0;
      ex_rd_we      <= 1'b0;
      ex_is_load    <= 1'b0;
      ex_is_store   <= 1'b0;
      ex_is_branch  <= 1'b0;
      ex_is_jump    <= 1'b0;
      ex_funct3     <= '0;
      ex_illegal    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      ex_valid <= accept;
      if (accept) begin
        ex_pc         <= if_pc;
        ex_src1       <= src1;
        ex_src2       <= src2;
        ex_store_data <= rs2_val;
        ex_imm        <= imm;
        ex_alu_op     <= alu_op;
        ex_rd         <= rd;
        ex_rd_we      <= rd_we;
        ex_is_load    <= is_load;
        ex_is_store   <= is_store;
        ex_is_branch  <= is_branch;
        ex_is_jump    <= is_jump;
        ex_funct3     <= if_inst[F3_LSB +: 3];
        ex_illegal    <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Scoreboard bench for pipeline_id_stage: directed instructions, expected results queued on issue.
// Latency: checks ex_* one cycle after IF acceptance.
// Backpressure: exercises ex_ready stalls, load-use bubbles and flush.
module tb_pipeline_id_stage;
  import riscv_pkg::*;

  logic        clk, rst;
  logic        if_valid, if_ready, flush;
  logic [31:0] if_inst, if_pc;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, ex_rd;
  logic [31:0] rf_rdata1, rf_rdata2, wb_data;
  logic        wb_we, ex_valid, ex_ready, ex_rd_we;
  logic [31:0] ex_pc, ex_src1, ex_src2, ex_store_data, ex_imm;
  logic [3:0]  ex_alu_op;
  logic        ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal;
  logic [2:0]  ex_funct3;

  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  pipeline_id_stage #(.XLEN(32), .REG_AW(5), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .if_pc(if_pc), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_store_data(ex_store_data), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        full;
    logic [31:0] pc, src1, src2, sd, imm;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rd_we;
    logic [2:0]  f3;
    logic [3:0]  cls;   // {load, store, branch, jump}
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] pc, src1, src2, sd, imm,
                              input logic [3:0] alu, input logic [4:0] rd, input logic rd_we,
                              input logic [2:0] f3, input logic [3:0] cls);
    exp_t e;
    e.id = id; e.full = 1'b1; e.pc = pc; e.src1 = src1; e.src2 = src2; e.sd = sd;
    e.imm = imm; e.alu = alu; e.rd = rd; e.rd_we = rd_we; e.f3 = f3; e.cls = cls;
    e.ill = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_ill(input int id, input logic [31:0] pc);
    exp_t e;
    e = mk(id, pc, 0, 0, 0, 0, ALU_ADD, 5'd0, 1'b0, 3'd0, 4'b0000);
    e.full = 1'b0;
    e.ill  = 1'b1;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    string p;
    p = $sformatf("id%0d", e.id);
    check({p, ".pc"},      ex_pc, e.pc);
    check({p, ".illegal"}, 32'(ex_illegal), 32'(e.ill));
    check({p, ".rd_we"},   32'(ex_rd_we), 32'(e.rd_we));
    check({p, ".class"},   32'({ex_is_load, ex_is_store, ex_is_branch, ex_is_jump}), 32'(e.cls));
    if (e.full) begin
      check({p, ".src1"},   ex_src1, e.src1);
      check({p, ".src2"},   ex_src2, e.src2);
      check({p, ".store"},  ex_store_data, e.sd);
      check({p, ".imm"},    ex_imm, e.imm);
      check({p, ".alu_op"}, 32'(ex_alu_op), 32'(e.alu));
      check({p, ".rd"},     32'(ex_rd), 32'(e.rd));
      check({p, ".funct3"}, 32'(ex_funct3), 32'(e.f3));
    end
  endtask

  // Monitor: a transfer (or a flush-squash) consumes the scoreboard head
  always @(negedge clk) begin
    if (!rst && ex_valid && (flush || ex_ready)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: ex_pc 0x%08h, scoreboard empty", ex_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (!flush) compare(mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until accepted (bounded), queueing its expected result
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    int n;
    n = 0;
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
    @(negedge clk);
    while (!if_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!if_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: id%0d if_ready 0, expected 1 within 20 cycles", e.id);
      if_valid = 1'b0;
      tick();
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      if_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hBAD0;  // must never be seen: x0 reads are zero
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;

    #3;
    check("rst.ex_valid", 32'(ex_valid), 0);
    check("rst.if_ready", 32'(if_ready), 1);
    check("rst.ex_pc",    ex_pc, 0);
    check("rst.ex_src1",  ex_src1, 0);
    tick();
    rst = 1'b0;

    // Basic decode patterns
    issue(32'h002081B3, 32'h100, mk(1, 32'h100, 5, 7, 7, 0, ALU_ADD, 3, 1, 3'd0, 4'b0000));
    issue(32'hFFF00293, 32'h104, mk(2, 32'h104, 0, 32'hFFFFFFFF, 32'h101F, 32'hFFFFFFFF,
                                    ALU_ADD, 5, 1, 3'd0, 4'b0000));
    issue(32'h402083B3, 32'h108, mk(3, 32'h108, 5, 7, 7, 0, ALU_SUB, 7, 1, 3'd0, 4'b0000));
    issue(32'h4030D413, 32'h10C, mk(4, 32'h10C, 5, 32'h403, 32'h1003, 32'h403,
                                    ALU_SRA, 8, 1, 3'd5, 4'b0000));
    issue(32'h12345637, 32'h110, mk(5, 32'h110, 0, 32'h12345000, 32'h1003, 32'h12345000,
                                    ALU_ADD, 12, 1, 3'd5, 4'b0000));
    issue(32'hFE208EE3, 32'h114, mk(6, 32'h114, 5, 7, 7, 32'hFFFFFFFC,
                                    ALU_SUB, 29, 0, 3'd0, 4'b0010));
    issue(32'h020081B3, 32'h118, mk_ill(7, 32'h118));

    // Load-use: LW x4 then ADD x6,x4,x4 -> one stall cycle, one bubble
    issue(32'h0000A203, 32'h120, mk(8, 32'h120, 5, 0, 0, 0, ALU_ADD, 4, 1, 3'd2, 4'b1000));
    if_valid = 1'b1; if_inst = 32'h00420333; if_pc = 32'h124;
    @(negedge clk);
    check("lu.stall_if_ready", 32'(if_ready), 0);
    check("lu.load_in_ex",     32'(ex_is_load), 1);
    tick();
    @(negedge clk);
    check("lu.bubble_valid",   32'(ex_valid), 0);
    check("lu.resume_ready",   32'(if_ready), 1);
    @(posedge clk);
    exp_q.push_back(mk(9, 32'h124, 32'h1004, 32'h1004, 32'h1004, 0, ALU_ADD, 6, 1, 3'd0, 4'b0000));
    #1;
    if_valid = 1'b0;
    tick();

    // Backpressure: three stalled cycles, output stable, nothing lost or duplicated
    issue(32'h00108493, 32'h130, mk(10, 32'h130, 5, 1, 5, 1, ALU_ADD, 9, 1, 3'd0, 4'b0000));
    ex_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00616513; if_pc = 32'h134;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d.if_ready", c), 32'(if_ready), 0);
      check($sformatf("bp%0d.ex_valid", c), 32'(ex_valid), 1);
      check($sformatf("bp%0d.ex_pc", c),    ex_pc, 32'h130);
      check($sformatf("bp%0d.ex_src2", c),  ex_src2, 1);
      tick();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    check("bp.release_ready", 32'(if_ready), 1);
    @(posedge clk);
    exp_q.push_back(mk(11, 32'h134, 7, 6, 32'h1006, 6, ALU_OR, 10, 1, 3'd6, 4'b0000));
    #1;
    if_valid = 1'b0;
    tick();
    @(negedge clk);
    check("bp.no_duplicate", 32'(ex_valid), 0);
    tick();

    // Write-back bypass, then flush while EX is stalled
    rf[1] = 32'd0;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
    issue(32'h00008593, 32'h140, mk(12, 32'h140, 32'hDEAD, 0, 0, 0, ALU_ADD, 11, 1, 3'd0, 4'b0000));
    ex_ready = 1'b0;
    wb_we = 1'b0;
    @(negedge clk);
    check("byp.ex_valid", 32'(ex_valid), 1);
    check("byp.ex_src1",  ex_src1, 32'hDEAD);
    tick();
    flush = 1'b1; if_valid = 1'b1; if_inst = 32'h0000007F; if_pc = 32'h144;
    @(negedge clk);
    check("fl.if_ready", 32'(if_ready), 0);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    check("fl.ex_valid", 32'(ex_valid), 0);
    tick();
    ex_ready = 1'b1;
    issue(32'h0000007F, 32'h144, mk_ill(13, 32'h144));
    tick();

    // Reset mid-stream while an instruction is held
    ex_ready = 1'b0;
    issue(32'h00108493, 32'h150, mk(14, 32'h150, 0, 1, 0, 1, ALU_ADD, 9, 1, 3'd0, 4'b0000));
    @(negedge clk);
    check("mrst.pre_valid", 32'(ex_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mrst.ex_valid", 32'(ex_valid), 0);
    check("mrst.ex_pc",    ex_pc, 0);
    check("mrst.ex_src1",  ex_src1, 0);
    check("mrst.ex_imm",   ex_imm, 0);
    check("mrst.ex_rd_we", 32'(ex_rd_we), 0);
    check("mrst.ex_alu",   32'(ex_alu_op), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());  // held instruction destroyed by reset
    tick();
    rst = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    check("mrst.if_ready", 32'(if_ready), 1);
    check("mrst.idle",     32'(ex_valid), 0);
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_id_stage.md
Name: pipeline_id_stage

Overview:
- Parametrised RV32I instruction-decode stage between IF and EX.
- Decodes all base RV32I formats and generates sign-extended immediates.
- Reads an external combinational register file, with write-back bypass.
- Detects load-use hazards and inserts bubbles, holding a registered ID/EX output under a valid/ready handshake with flush support.

Parameters:
XLEN, 32, datapath width; immediates sign-extended to XLEN.
REG_AW, 5, register address width (2**REG_AW architectural registers).
ALU_OP_W, 4, width of ALU opcode field.

Ports:
clk  in  1  clock
rst  in  1  reset
if_valid  in  1  IF presents an instruction
if_ready  out  1  ID accepts the instruction this cycle
if_inst  in  32  raw instruction word
if_pc  in  XLEN  PC of if_inst
flush  in  1  squash the instruction held at the ID/EX output and the one being accepted
rf_raddr1  out  REG_AW  regfile read address 1, combinational from if_inst[19:15]
rf_raddr2  out  REG_AW  regfile read address 2, combinational from if_inst[24:20]
rf_rdata1  in  XLEN  regfile read data 1 (combinational)
rf_rdata2  in  XLEN  regfile read data 2 (combinational)
wb_we  in  1  write-back write enable
wb_rd  in  REG_AW  write-back destination
wb_data  in  XLEN  write-back data
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ready  in  1  EX accepts ID/EX contents this cycle
ex_pc  out  XLEN  instruction PC
ex_src1  out  XLEN  operand A (rs1 value, PC for AUIPC/JAL, 0 for LUI)
ex_src2  out  XLEN  operand B (rs2 value for OP/BRANCH, else immediate)
ex_store_data  out  XLEN  rs2 value
ex_imm  out  XLEN  sign-extended immediate
ex_alu_op  out  ALU_OP_W  ALU operation
ex_rd  out  REG_AW  destination register
ex_rd_we  out  1  destination write enable
ex_is_load / ex_is_store / ex_is_branch / ex_is_jump  out  1 each  class flags
ex_funct3  out  3  funct3, passed through for MEM/branch units
ex_illegal  out  1  unsupported opcode or funct encoding

Behaviour:
- Reset (async, active-high) clears every ex_* output to 0. if_ready is combinational and therefore 1 after reset.
- Latency: one cycle. An instruction accepted on edge N appears on ex_* after edge N.
- Handshake:
  - advance = !ex_valid || ex_ready.
  - hazard = load-use condition (below).
  - if_ready = advance && !hazard && !flush.
- ex_* update only when advance. While ex_valid && !ex_ready, all ex_* hold stable.
- On advance:
  - If if_valid && if_ready: the decoded instruction loads and ex_valid is set to 1.
  - Otherwise ex_valid is cleared to 0 (bubble); other ex_* are don't-care but must not X-propagate.
- Flush has highest priority. On the next edge ex_valid=0 regardless of ex_ready, and the IF instruction is not accepted that cycle.
- Load-use hazard:
  - Condition: ex_valid && ex_is_load && ex_rd!=0, and either (uses_rs1 && rs1==ex_rd) or (uses_rs2 && rs2==ex_rd).
  - While the hazard holds, if_ready=0. When ex_ready, a bubble enters ID/EX.
  - The hazard clears the following cycle because the load has left ID/EX.
- Bypass: if wb_we && wb_rd!=0 && wb_rd==rs, the operand uses wb_data instead of rf_rdata.
- x0 handling: reads of x0 yield 0. rd==0 forces ex_rd_we=0.
- Decode by opcode; the source-usage flags are:
  - OP: uses rs1, rs2.
  - OP-IMM: uses rs1.
  - LOAD: uses rs1.
  - STORE: uses rs1, rs2.
  - BRANCH: uses rs1, rs2.
  - LUI: uses neither.
  - AUIPC: uses neither.
  - JAL: uses neither.
  - JALR: uses rs1.
- Immediate formats I/S/B/U/J per RISC-V spec, sign-extended to XLEN. The U immediate is imm<<12.
- ALU op selection:
  - OP and OP-IMM: from funct3 plus funct7[5]. SUB/SRA need funct7=0100000; SRAI needs imm[11:5]=0100000.
  - LOAD, STORE, JAL, JALR, AUIPC, LUI: ADD.
  - BRANCH: SUB.
- ex_illegal=1 for:
  - an unknown opcode;
  - OP with funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101};
  - OP-IMM shift with an illegal funct7.
- An illegal instruction still flows with ex_valid=1, ex_rd_we=0, and all class flags 0.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants;
  - funct3/funct7 constants;
  - ALU opcode encodings (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND);
  - instruction field bit positions;
  - the immediate-format enum.
- One sub-module: id_decoder, purely combinational. It maps inst to {imm, alu_op, flags, uses_rs1/2, illegal}. The stage module owns the handshake, hazard, bypass and registers.

Test Plan:
- Reset mid-stream: assert rst while ex_valid=1 -> ex_valid=0, all ex_* 0 asynchronously; if_ready=1 after release.
- ADD x3,x1,x2 (0x002081B3) with rf x1=5, x2=7 -> next cycle ex_src1=5, ex_src2=7, ex_alu_op=ALU_ADD, ex_rd=3, ex_rd_we=1.
- ADDI x5,x0,-1 (0xFFF00293) -> ex_imm=0xFFFFFFFF, ex_src1=0, ex_src2=0xFFFFFFFF; SUB/SRAI produce ALU_SUB/ALU_SRA.
- LW x4,0(x1) followed by ADD x6,x4,x4 with ex_ready=1 -> if_ready=0 for one cycle, one bubble (ex_valid=0), then the ADD is accepted.
- Backpressure: ex_ready=0 for 3 cycles with if_valid=1 -> ex_* stable, if_ready=0; release -> the next instruction is accepted, none lost or duplicated.
- Bypass plus flush: wb_we=1, wb_rd=1, wb_data=0xDEAD with rf x1=0 -> ex_src1=0xDEAD; flush with ex_ready=0 -> ex_valid=0 next cycle; opcode 0x7F -> ex_illegal=1, ex_rd_we=0.
